// File: rtl/commit_arbiter.sv
// commit_arbiter: round-robin commit of ALU/LS pipeline results onto the register-file write port.
// Define COMMIT_ARB_RETIRE_CNT_EN to add the retired-instruction counter port retire_cnt_o.
package commit_arbiter_pkg;
  localparam int OpW     = 65;
  localparam int McauseW = 6;
  localparam int MtvalW  = 32;

  typedef struct packed {
    logic               we;
    logic [4:0]         waddr;
    logic [OpW-1:0]     wdata;
    logic               is_cap;
    logic               wrsv;
    logic               err;
    logic [31:0]        pc;
    logic [McauseW-1:0] mcause;
    logic [MtvalW-1:0]  mtval;
  } pl_out_t;
endpackage

module commit_arbiter
  import commit_arbiter_pkg::*;
#(
  parameter bit CHERIoTEn = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               alupl_valid_i,
  input  pl_out_t            alupl_output_i,
  output logic               alupl_rdy_o,
  input  logic               lspl_valid_i,
  input  pl_out_t            lspl_output_i,
  output logic               lspl_rdy_o,
  output logic               rf_we_o,
  output logic [4:0]         rf_waddr_o,
  output logic [OpW-1:0]     rf_wdata_o,
  output logic               rf_wcap_o,
  output logic               rsv_clr_o,
  output logic [4:0]         rsv_addr_o,
  output logic               exc_valid_o,
  output logic [31:0]        exc_pc_o,
  output logic [McauseW-1:0] exc_mcause_o,
  output logic [MtvalW-1:0]  exc_mtval_o
`ifdef COMMIT_ARB_RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_cnt_o
`endif
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t             r_state;
  logic               r_rr;
  logic               r_rf_we;
  logic [4:0]         r_rf_waddr;
  logic [OpW-1:0]     r_rf_wdata;
  logic               r_rf_wcap;
  logic               r_rsv_clr;
  logic               r_exc_valid;
  logic [31:0]        r_exc_pc;
  logic [McauseW-1:0] r_exc_mcause;
  logic [MtvalW-1:0]  r_exc_mtval;

  logic               w_open;
  logic               w_both;
  logic               w_gnt_alu;
  logic               w_gnt_ls;
  logic               w_acc;
  pl_out_t            w_res;
  logic [OpW-1:0]     w_wdata;

  assign w_open    = (r_state == RUN) && !flush_i;
  assign w_both    = alupl_valid_i && lspl_valid_i;
  assign w_gnt_alu = w_open && alupl_valid_i && (!lspl_valid_i || !r_rr);
  assign w_gnt_ls  = w_open && lspl_valid_i && (!alupl_valid_i || r_rr);
  assign w_acc     = w_gnt_alu || w_gnt_ls;
  assign w_res     = w_gnt_ls ? lspl_output_i : alupl_output_i;
  // Without capabilities only the low word is architectural; keep the rest quiet.
  assign w_wdata   = CHERIoTEn ? w_res.wdata : {{(OpW-32){1'b0}}, w_res.wdata[31:0]};

  assign alupl_rdy_o = w_gnt_alu;
  assign lspl_rdy_o  = w_gnt_ls;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= RUN;
      r_rr         <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_rf_wcap    <= 1'b0;
      r_rsv_clr    <= 1'b0;
      r_exc_valid  <= 1'b0;
      r_exc_pc     <= '0;
      r_exc_mcause <= '0;
      r_exc_mtval  <= '0;
    end else begin
      r_rf_we     <= 1'b0;
      r_rsv_clr   <= 1'b0;
      r_exc_valid <= 1'b0;
      if (flush_i) begin
        r_state <= RUN;
      end else if (w_acc) begin
        r_rf_we      <= w_res.we && !w_res.err;
        r_rf_waddr   <= w_res.waddr;
        r_rf_wdata   <= w_wdata;
        r_rf_wcap    <= w_res.is_cap;
        r_rsv_clr    <= w_res.wrsv && !w_res.err;
        r_exc_valid  <= w_res.err;
        r_exc_pc     <= w_res.pc;
        r_exc_mcause <= w_res.mcause;
        r_exc_mtval  <= w_res.mtval;
        if (w_res.err) r_state <= HALT;
        if (w_both) r_rr <= !r_rr;
      end
    end
  end

  assign rf_we_o      = r_rf_we;
  assign rf_waddr_o   = r_rf_waddr;
  assign rf_wdata_o   = r_rf_wdata;
  assign rf_wcap_o    = r_rf_wcap;
  assign rsv_clr_o    = r_rsv_clr;
  assign rsv_addr_o   = r_rf_waddr;
  assign exc_valid_o  = r_exc_valid;
  assign exc_pc_o     = r_exc_pc;
  assign exc_mcause_o = r_exc_mcause;
  assign exc_mtval_o  = r_exc_mtval;

`ifdef COMMIT_ARB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_retire_cnt <= '0;
    end else if (w_acc && !w_res.err) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt_o = r_retire_cnt;
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter: directed and randomized stimulus against a scoreboarded reference model.
module tb_commit_arbiter;
  import commit_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic av = 1'b0, lv = 1'b0;
  pl_out_t ao = '0, lo = '0;

  logic               alupl_rdy, lspl_rdy, rf_we, rf_wcap, rsv_clr, exc_valid;
  logic [4:0]         rf_waddr, rsv_addr;
  logic [OpW-1:0]     rf_wdata;
  logic [31:0]        exc_pc;
  logic [McauseW-1:0] exc_mcause;
  logic [MtvalW-1:0]  exc_mtval;
  logic [31:0]        retire_cnt;

  commit_arbiter dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .alupl_valid_i(av), .alupl_output_i(ao), .alupl_rdy_o(alupl_rdy),
    .lspl_valid_i(lv), .lspl_output_i(lo), .lspl_rdy_o(lspl_rdy),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_wcap_o(rf_wcap),
    .rsv_clr_o(rsv_clr), .rsv_addr_o(rsv_addr),
    .exc_valid_o(exc_valid), .exc_pc_o(exc_pc), .exc_mcause_o(exc_mcause), .exc_mtval_o(exc_mtval)
`ifdef COMMIT_ARB_RETIRE_CNT_EN
    , .retire_cnt_o(retire_cnt)
`endif
  );

`ifndef COMMIT_ARB_RETIRE_CNT_EN
  assign retire_cnt = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic               we;
    logic [4:0]         waddr;
    logic [OpW-1:0]     wdata;
    logic               wcap;
    logic               rsv;
    logic               exc;
    logic [31:0]        pc;
    logic [McauseW-1:0] mcause;
    logic [MtvalW-1:0]  mtval;
    logic [31:0]        cnt;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // Reference model state
  logic m_halt = 1'b0;
  logic m_rr = 1'b0;
  exp_t m_out;
  logic s_ardy, s_lrdy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_out.we = 0; m_out.waddr = 0; m_out.wdata = 0; m_out.wcap = 0; m_out.rsv = 0;
    m_out.exc = 0; m_out.pc = 0; m_out.mcause = 0; m_out.mtval = 0; m_out.cnt = 0;
    m_halt = 0; m_rr = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rf_we", rf_we, e.we);
      chk("rf_waddr", rf_waddr, e.waddr);
      chk("rf_wdata", rf_wdata, e.wdata);
      chk("rf_wcap", rf_wcap, e.wcap);
      chk("rsv_clr", rsv_clr, e.rsv);
      chk("rsv_addr", rsv_addr, e.waddr);
      chk("exc_valid", exc_valid, e.exc);
      chk("exc_pc", exc_pc, e.pc);
      chk("exc_mcause", exc_mcause, e.mcause);
      chk("exc_mtval", exc_mtval, e.mtval);
`ifdef COMMIT_ARB_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt, e.cnt);
`endif
    end
  end

  // One cycle: drive at negedge, check rdy before the edge, update model at the edge.
  task automatic step(input logic a_v, input pl_out_t a_o, input logic l_v, input pl_out_t l_o,
                      input logic fl);
    logic ga, gl;
    pl_out_t r;
    @(negedge clk);
    av = a_v; ao = a_o; lv = l_v; lo = l_o; flush = fl;
    #1;
    ga = 0; gl = 0;
    if (!m_halt && !fl) begin
      if (a_v && l_v) begin
        if (m_rr) gl = 1; else ga = 1;
      end else begin
        ga = a_v; gl = l_v;
      end
    end
    s_ardy = alupl_rdy; s_lrdy = lspl_rdy;
    chk("alu_rdy", alupl_rdy, ga);
    chk("ls_rdy", lspl_rdy, gl);
    @(posedge clk);
    m_out.we = 0; m_out.rsv = 0; m_out.exc = 0;
    if (fl) begin
      m_halt = 0;
    end else if (ga || gl) begin
      r = ga ? a_o : l_o;
      m_out.we = r.we & ~r.err;
      m_out.waddr = r.waddr;
      m_out.wdata = r.wdata;
      m_out.wcap = r.is_cap;
      m_out.rsv = r.wrsv & ~r.err;
      m_out.exc = r.err;
      m_out.pc = r.pc;
      m_out.mcause = r.mcause;
      m_out.mtval = r.mtval;
      if (r.err) m_halt = 1;
      else m_out.cnt = m_out.cnt + 1;
      if (a_v && l_v) m_rr = !m_rr;
    end
    q.push_back(m_out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; av = 0; lv = 0; flush = 0;
    #1;
    chk("rst_valids", {rf_we, rsv_clr, exc_valid, alupl_rdy, lspl_rdy}, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_exc_pc", exc_pc, 0);
    chk("rst_misc", {rf_waddr, rf_wcap, rsv_addr, exc_mcause, exc_mtval}, 0);
    chk("rst_cnt", retire_cnt, 0);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  function automatic pl_out_t rnd_res();
    pl_out_t r;
    r.we = 1'($urandom);
    r.waddr = 5'($urandom);
    r.wdata = {1'($urandom), 32'($urandom), 32'($urandom)};
    r.is_cap = 1'($urandom);
    r.wrsv = 1'($urandom);
    r.err = ($urandom_range(0, 7) == 0);
    r.pc = $urandom;
    r.mcause = 6'($urandom);
    r.mtval = $urandom;
    return r;
  endfunction

  initial begin
    pl_out_t ra, rl, idle;
    logic [31:0] cnt_exp [3];
    idle = '0;
    model_clear();
    do_reset();

    // ALU only, valid held high
    ra = '0; ra.we = 1; ra.waddr = 5; ra.wdata = 65'h1234;
    for (int i = 0; i < 5; i++) begin
      step(1, ra, 0, idle, 0);
      chk("alu_only_rdy", s_ardy, 1);
      #1;
      chk("alu_only_we", rf_we, 1);
      chk("alu_only_waddr", rf_waddr, 5);
      chk("alu_only_wdata", rf_wdata, 65'h1234);
    end

    // Both valid from reset: ALU, LS, ALU, LS
    do_reset();
    ra = '0; ra.we = 1; ra.waddr = 1; ra.wdata = 65'h11;
    rl = '0; rl.we = 1; rl.waddr = 2; rl.wdata = 65'h22;
    for (int i = 0; i < 4; i++) begin
      step(1, ra, 1, rl, 0);
      chk("rr_alu", s_ardy, (i % 2) == 0);
      chk("rr_ls", s_lrdy, (i % 2) == 1);
    end

    // LS exception, halt for 10 cycles, then flush
    rl = '0; rl.we = 1; rl.err = 1; rl.mcause = 5; rl.pc = 32'h80; rl.waddr = 3;
    step(0, idle, 1, rl, 0);
    #1;
    chk("exc_valid_dir", exc_valid, 1);
    chk("exc_pc_dir", exc_pc, 32'h80);
    chk("exc_mcause_dir", exc_mcause, 5);
    chk("exc_we_dir", rf_we, 0);
    ra = '0; ra.we = 1; ra.waddr = 7;
    for (int i = 0; i < 10; i++) begin
      step(1, ra, 1, ra, 0);
      chk("halt_rdy", {s_ardy, s_lrdy}, 0);
    end
    step(1, ra, 0, idle, 1);
    chk("flush_rdy", s_ardy, 0);
    step(1, ra, 0, idle, 0);
    chk("resume_rdy", s_ardy, 1);

    // Flush with ALU valid and wrsv
    ra = '0; ra.we = 1; ra.wrsv = 1; ra.waddr = 9;
    step(1, ra, 0, idle, 1);
    chk("flush_noacc", s_ardy, 0);
    #1;
    chk("flush_rsv", rsv_clr, 0);
    chk("flush_we", rf_we, 0);

`ifdef COMMIT_ARB_RETIRE_CNT_EN
    // Preloaded counter wrap
    @(negedge clk);
    av = 0; lv = 0; flush = 0;
    force dut.r_retire_cnt = 32'hFFFF_FFFE;
    m_out.cnt = 32'hFFFF_FFFE;
    step(0, idle, 0, idle, 0);
    @(negedge clk);
    release dut.r_retire_cnt;
    cnt_exp[0] = 32'hFFFF_FFFF; cnt_exp[1] = 32'h0; cnt_exp[2] = 32'h1;
    ra = '0; ra.we = 1; ra.waddr = 4;
    for (int i = 0; i < 3; i++) begin
      step(1, ra, 0, idle, 0);
      #1;
      chk("cnt_wrap", retire_cnt, cnt_exp[i]);
    end
`else
    cnt_exp[0] = 0; cnt_exp[1] = 0; cnt_exp[2] = 0;
`endif

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 2000; i++) begin
      logic fl;
      if (i == 1000) do_reset();
      fl = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      step(1'($urandom), rnd_res(), 1'($urandom), rnd_res(), fl);
    end

    step(0, idle, 0, idle, 1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
